// File: rtl/modulo_varredura_decod_16.sv
// Demux-16 scan sweeper: steps a slot index with a programmable dwell,
// decodes it to 1-based (column,row) and hands each slot downstream via valid/ready.
module modulo_varredura_decod_16 #(
   parameter int DWELL     = 4,
   parameter int LAST_SLOT = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       load,
   input  logic [3:0] load_sel,
   input  logic       ready,
   output logic [3:0] dmx16_sel,
   output logic [2:0] mdc,
   output logic [2:0] mdl,
   output logic       valid,
   output logic       frame_done,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE,
      DWELL_ST,
      PRESENT
   } state_t;

   localparam logic [7:0] CNT_INIT = 8'(DWELL - 1);
   localparam logic [3:0] LAST     = 4'(LAST_SLOT);

   state_t     state;
   logic [7:0] cnt;

   assign mdc = {1'b0, dmx16_sel[1:0]} + 3'd1;
   assign mdl = {1'b0, dmx16_sel[3:2]} + 3'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= 8'd0;
         dmx16_sel  <= 4'd0;
         valid      <= 1'b0;
         frame_done <= 1'b0;
         busy       <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (load) begin
            // out-of-range targets restart the sweep at slot 0
            dmx16_sel <= (load_sel > LAST) ? 4'd0 : load_sel;
            valid     <= 1'b0;
            if (en) begin
               state <= DWELL_ST;
               cnt   <= CNT_INIT;
               busy  <= 1'b1;
            end else begin
               state <= IDLE;
               cnt   <= 8'd0;
               busy  <= 1'b0;
            end
         end else begin
            unique case (state)
               IDLE: begin
                  if (en) begin
                     state <= DWELL_ST;
                     cnt   <= CNT_INIT;
                     busy  <= 1'b1;
                  end
               end
               DWELL_ST: begin
                  if (!en) begin
                     state <= IDLE;
                     cnt   <= 8'd0;
                     busy  <= 1'b0;
                  end else if (cnt == 8'd0) begin
                     state <= PRESENT;
                     valid <= 1'b1;
                  end else begin
                     cnt <= cnt - 8'd1;
                  end
               end
               PRESENT: begin
                  if (ready) begin
                     valid <= 1'b0;
                     if (dmx16_sel == LAST) begin
                        dmx16_sel  <= 4'd0;
                        frame_done <= 1'b1;
                     end else begin
                        dmx16_sel <= dmx16_sel + 4'd1;
                     end
                     if (en) begin
                        state <= DWELL_ST;
                        cnt   <= CNT_INIT;
                     end else begin
                        state <= IDLE;
                        cnt   <= 8'd0;
                        busy  <= 1'b0;
                     end
                  end
               end
               default: begin
                  state <= IDLE;
                  cnt   <= 8'd0;
                  valid <= 1'b0;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
